// File: rtl/dram_pkg.sv
// dram_pkg: FSM state encoding, timing defaults, CAS encodings and the 68030 lane decode shared by dram_ctl.
//   DRAMCTL_BURST_EN adds the burst CAS-precharge state BPRE.
package dram_pkg;

    localparam int MA_BITS          = 13;
    localparam int T_RCD_DEF        = 2;
    localparam int T_CAS_DEF        = 2;
    localparam int T_RP_DEF         = 3;
    localparam int REF_INTERVAL_DEF = 780;

    localparam logic [3:0] CAS_ALL  = 4'h0;
    localparam logic [3:0] CAS_NONE = 4'hF;

`ifdef DRAMCTL_BURST_EN
    typedef enum logic [3:0] {IDLE, RCD, CAS, ACK, PRE, REF_CAS, REF_RAS, REF_PRE, BPRE} state_t;
`else
    typedef enum logic [3:0] {IDLE, RCD, CAS, ACK, PRE, REF_CAS, REF_RAS, REF_PRE} state_t;
`endif

    // Active-low column strobes for a 32-bit port; nCAS[3] is byte offset 0.
    // Reads strobe every lane; writes strobe offsets a .. a+size-1, clipped at offset 3.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a, input logic rnw);
        logic [2:0] n;
        logic [3:0] m;
        n = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        m = CAS_NONE;
        for (int o = 0; o < 4; o++)
            if (o >= int'(a) && o < int'(a) + int'(n)) m[3 - o] = 1'b0;
        return rnw ? CAS_ALL : m;
    endfunction

endpackage

// File: rtl/dram_ctl_if.sv
// dram_ctl_if: 68030 bus side and DRAM side of one SIMM bank.
//   master: bus/system controller side (drives strobes, address, size); slave: the controller.
interface dram_ctl_if;
    import dram_pkg::*;

    logic               nDRAMSEL;
    logic               nAS;
    logic               nDS;
    logic               RnW;
    logic [1:0]         SIZ;
    logic [27:0]        ADDR;
    logic               nCBREQ;
    logic [1:0]         DSACK;
    logic               CBACK;
    logic               nRAS;
    logic [3:0]         nCAS;
    logic               nWE;
    logic [MA_BITS-1:0] MA;

    modport master (output nDRAMSEL, nAS, nDS, RnW, SIZ, ADDR, nCBREQ,
                    input  DSACK, CBACK, nRAS, nCAS, nWE, MA);
    modport slave  (input  nDRAMSEL, nAS, nDS, RnW, SIZ, ADDR, nCBREQ,
                    output DSACK, CBACK, nRAS, nCAS, nWE, MA);

endinterface

// File: rtl/dram_refresh_timer.sv
// dram_refresh_timer: free-running refresh interval counter with a sticky request flag.
//   DRAM_CLK, RESET (async, active high); refClr in clears the request; refPending out.
//   Expiries while a request is already pending are dropped on purpose.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
    input  logic DRAM_CLK,
    input  logic RESET,
    input  logic refClr,
    output logic refPending
);
    localparam int W = $clog2(REF_INTERVAL);

    logic [W-1:0] count;
    logic         expire;

    assign expire = count == W'(REF_INTERVAL - 1);

    // A new expiry wins over a clear on the same edge.
    always_ff @(posedge DRAM_CLK or posedge RESET) begin
        if (RESET) begin
            count      <= '0;
            refPending <= 1'b0;
        end else begin
            count      <= expire ? '0 : count + W'(1);
            refPending <= expire | (refPending & ~refClr);
        end
    end

endmodule

// File: rtl/dram_ctl.sv
// dram_ctl: one-bank FPM DRAM controller turning 68030 async bus cycles into RAS/CAS/WE/MA, with CBR refresh.
//   DRAM_CLK, RESET (async, active high); bus: dram_ctl_if.slave (CPU strobes in; DSACK/CBACK and DRAM strobes out).
//   DRAMCTL_BURST_EN: enables cache line burst reads (CBACK, up to 4 longwords); otherwise CBACK is tied low.
module dram_ctl
    import dram_pkg::*;
#(
    parameter int T_RCD        = T_RCD_DEF,
    parameter int T_CAS        = T_CAS_DEF,
    parameter int T_RP         = T_RP_DEF,
    parameter int REF_INTERVAL = REF_INTERVAL_DEF
) (
    input logic       DRAM_CLK,
    input logic       RESET,
    dram_ctl_if.slave bus
);
    localparam int CW = 4;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         asSync, selSync;
    logic               asN, selN, start, endAccess, refPending, refClr;
    logic               nRasR, nWeR, nWeLat;
    logic [3:0]         nCasR, laneR;
    logic [MA_BITS-1:0] maR, colR;
    logic [1:0]         dsackR;

    dram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) uRefTimer (
        .DRAM_CLK  (DRAM_CLK),
        .RESET     (RESET),
        .refClr    (refClr),
        .refPending(refPending)
    );

    always_ff @(posedge DRAM_CLK or posedge RESET) begin
        if (RESET) begin
            asSync  <= 2'b11;
            selSync <= 2'b11;
        end else begin
            asSync  <= {asSync[0], bus.nAS};
            selSync <= {selSync[0], bus.nDRAMSEL};
        end
    end

    assign asN   = asSync[1];
    assign selN  = selSync[1];
    assign start = ~asN & ~selN;
    // nAS going away mid-access (BERR) and normal termination both release the row the same way.
    assign endAccess = asN && (state == RCD || state == CAS || state == ACK);
    assign refClr    = state == REF_PRE && cnt == CW'(T_RP - 1);

`ifdef DRAMCTL_BURST_EN
    logic [1:0] dsSync, cbSync, beat;
    logic       dsN, cbreqN, cbackR;

    always_ff @(posedge DRAM_CLK or posedge RESET) begin
        if (RESET) begin
            dsSync <= 2'b11;
            cbSync <= 2'b11;
        end else begin
            dsSync <= {dsSync[0], bus.nDS};
            cbSync <= {cbSync[0], bus.nCBREQ};
        end
    end

    assign dsN       = dsSync[1];
    assign cbreqN    = cbSync[1];
    assign bus.CBACK = cbackR;
`else
    assign bus.CBACK = 1'b0;
`endif

    always_ff @(posedge DRAM_CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            nRasR  <= 1'b1;
            nCasR  <= CAS_NONE;
            nWeR   <= 1'b1;
            nWeLat <= 1'b1;
            maR    <= '0;
            colR   <= '0;
            laneR  <= CAS_NONE;
            dsackR <= 2'b00;
`ifdef DRAMCTL_BURST_EN
            cbackR <= 1'b0;
            beat   <= 2'd0;
`endif
        end else if (endAccess) begin
            state  <= PRE;
            cnt    <= '0;
            nRasR  <= 1'b1;
            nCasR  <= CAS_NONE;
            nWeR   <= 1'b1;
            dsackR <= 2'b00;
`ifdef DRAMCTL_BURST_EN
            cbackR <= 1'b0;
`endif
        end else begin
            case (state)
                // Refresh has priority; a start seen on the same edge waits for it.
                IDLE: if (refPending) begin
                    state <= REF_CAS;
                    nCasR <= CAS_ALL;
                end else if (start) begin
                    state  <= RCD;
                    cnt    <= '0;
                    nRasR  <= 1'b0;
                    maR    <= bus.ADDR[27:15];
                    colR   <= bus.ADDR[14:2];
                    laneR  <= lane_mask(bus.SIZ, bus.ADDR[1:0], bus.RnW);
                    nWeLat <= bus.RnW;
`ifdef DRAMCTL_BURST_EN
                    beat   <= 2'd0;
`endif
                end
                // Column address and early-write nWE settle before CAS falls.
                RCD: begin
                    maR  <= colR;
                    nWeR <= nWeLat;
                    if (cnt == CW'(T_RCD - 1)) begin
                        state <= CAS;
                        cnt   <= '0;
                        nCasR <= laneR;
                    end else cnt <= cnt + CW'(1);
                end
                CAS: if (cnt == CW'(T_CAS - 1)) begin
                    state  <= ACK;
                    dsackR <= 2'b11;
`ifdef DRAMCTL_BURST_EN
                    if (beat == 2'd0) cbackR <= nWeLat & ~cbreqN;
`endif
                end else cnt <= cnt + CW'(1);
`ifdef DRAMCTL_BURST_EN
                // Next beat: nDS released while nAS held; column wraps within the 16-byte line.
                ACK: if (cbackR && cbreqN) cbackR <= 1'b0;
                else if (cbackR && dsN) begin
                    state  <= BPRE;
                    dsackR <= 2'b00;
                    nCasR  <= CAS_NONE;
                    maR    <= {colR[MA_BITS-1:2], colR[1:0] + 2'd1};
                    colR   <= {colR[MA_BITS-1:2], colR[1:0] + 2'd1};
                    beat   <= beat + 2'd1;
                    cbackR <= beat != 2'd2;
                end
                BPRE: begin
                    state <= CAS;
                    cnt   <= '0;
                    nCasR <= laneR;
                end
`endif
                PRE: if (cnt == CW'(T_RP - 1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                REF_CAS: begin
                    state <= REF_RAS;
                    cnt   <= '0;
                    nRasR <= 1'b0;
                end
                REF_RAS: if (cnt == CW'(T_RCD + T_CAS - 1)) begin
                    state <= REF_PRE;
                    cnt   <= '0;
                    nRasR <= 1'b1;
                    nCasR <= CAS_NONE;
                end else cnt <= cnt + CW'(1);
                REF_PRE: if (cnt == CW'(T_RP - 1)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + CW'(1);
                default: ;
            endcase
        end
    end

    assign bus.nRAS  = nRasR;
    assign bus.nCAS  = nCasR;
    assign bus.nWE   = nWeR;
    assign bus.MA    = maR;
    // Raw nDS so DSACK follows the CPU's strobe release without synchronizer delay.
    assign bus.DSACK = dsackR & {2{~bus.nDS}};

endmodule

// File: tb/tb_dram_ctl.sv
// tb_dram_ctl: scoreboard bench for dram_ctl; expectations queued at stimulus, compared on each DSACK.
module tb_dram_ctl;
    import dram_pkg::*;

    typedef struct {
        logic [12:0] row;
        logic [12:0] col;
        logic [3:0]  cas;
        logic        we;
        logic        cback;
        int          t0;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errCnt = 0;
    int   chkCnt = 0;
    exp_t sb[$];

    always #10 clk = ~clk;

    dram_ctl_if bus ();

    dram_ctl dut (
        .DRAM_CLK(clk),
        .RESET   (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    logic        prevRas = 1'b1, prevWe = 1'b1;
    logic [3:0]  prevCas = 4'hF;
    logic [1:0]  prevDsack = 2'b00;
    logic [12:0] rowSeen = '0, colSeen = '0;
    logic [3:0]  casSeen = 4'hF;
    logic        weSeen = 1'b1;
    int          refCasCyc = 0, refRasCyc = 0, rasLow = 0, lastRasLow = 0;
    exp_t        m;

    always @(negedge clk) begin
        if (!rst) begin
            if (prevRas && !bus.nRAS) begin
                if (bus.nCAS == 4'hF) rowSeen <= bus.MA;
                else refRasCyc <= cyc;
            end
            rasLow <= bus.nRAS ? 0 : rasLow + 1;
            if (!prevRas && bus.nRAS) lastRasLow <= rasLow;
            if (prevCas == 4'hF && bus.nCAS != 4'hF) begin
                if (!bus.nRAS) begin
                    colSeen <= bus.MA;
                    casSeen <= bus.nCAS;
                    weSeen  <= prevWe;
                end else refCasCyc <= cyc;
            end
            if (bus.DSACK == 2'b11 && prevDsack != 2'b11) begin
                check("dsack_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    m = sb.pop_front();
                    check("row", rowSeen, m.row);
                    check("col", colSeen, m.col);
                    check("ncas", casSeen, m.cas);
                    check("nwe_early", weSeen, m.we);
                    check("cback", bus.CBACK, m.cback);
                    if (m.lat != 0) check("latency", cyc - m.t0, m.lat);
                end
            end
        end
        prevRas   <= bus.nRAS;
        prevCas   <= bus.nCAS;
        prevWe    <= bus.nWE;
        prevDsack <= bus.DSACK;
    end

    task automatic waitLeft(input int left, input int budget);
        int n = 0;
        while (sb.size() > left && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("sb_drain", sb.size(), left);
    endtask

    task automatic access(input logic rnw, input logic [1:0] siz, input logic [27:0] addr,
                          input logic [3:0] cas, input int lat, input int startAt);
        exp_t e;
        @(negedge clk);
        while (cyc < startAt) @(negedge clk);
        e.row = addr[27:15]; e.col = addr[14:2]; e.cas = cas; e.we = rnw;
        e.cback = 1'b0; e.t0 = cyc; e.lat = lat;
        sb.push_back(e);
        bus.ADDR = addr; bus.RnW = rnw; bus.SIZ = siz; bus.nDS = 1'b0; bus.nAS = 1'b0;
        waitLeft(0, 60);
    endtask

    task automatic endCycle();
        #2;
        bus.nDS = 1'b1;
        bus.nAS = 1'b1;
        #1;
        check("dsack_release", bus.DSACK, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ras_hold", bus.nRAS, 0);
        @(posedge clk);
        @(negedge clk);
        check("strobes_release", {bus.nRAS, bus.nCAS, bus.nWE}, 6'h3F);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.nDRAMSEL = 1'b0; bus.nAS = 1'b1; bus.nDS = 1'b1; bus.RnW = 1'b1;
        bus.SIZ = 2'b00; bus.ADDR = '0; bus.nCBREQ = 1'b1;
        #5 rst = 1'b1;
        #1;
        check("reset_strobes", {bus.nRAS, bus.nCAS, bus.nWE}, 6'h3F);
        check("reset_ma", bus.MA, 0);
        check("reset_ack", {bus.DSACK, bus.CBACK}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Long read, then writes across the lane table
        access(1'b1, 2'b00, 28'h123_4568, 4'b0000, 7, 0); endCycle();
        access(1'b0, 2'b01, 28'h0AB_CDE2, 4'b1101, 7, 0); endCycle();
        access(1'b0, 2'b10, 28'h765_4321, 4'b1001, 7, 0); endCycle();
        access(1'b0, 2'b11, 28'h0F0_0F00, 4'b0001, 7, 0); endCycle();
        access(1'b0, 2'b01, 28'h111_1110, 4'b0111, 7, 0); endCycle();
        access(1'b0, 2'b10, 28'h222_2222, 4'b1100, 7, 0); endCycle();
        access(1'b0, 2'b00, 28'hFFF_FFFC, 4'b0000, 7, 0); endCycle();

        // Bank not selected: nAS alone must not open a row
        @(negedge clk);
        bus.nDRAMSEL = 1'b1; bus.nAS = 1'b0;
        repeat (8) @(negedge clk);
        check("unselected_ras", bus.nRAS, 1);
        bus.nAS = 1'b1;
        repeat (4) @(negedge clk);
        bus.nDRAMSEL = 1'b0;

        // Idle refresh at the first timer expiry
        while (cyc < 800) @(negedge clk);
        check("ref_cas_cyc", refCasCyc, 781);
        check("ref_cas_to_ras", refRasCyc - refCasCyc, 1);
        check("ref_ras_low", lastRasLow, 4);
        check("ref_pending_clr", dut.refPending, 0);

        // Start lands on the same edge as expiry: refresh (9 cycles) then the normal 7
        access(1'b1, 2'b00, 28'h345_6788, 4'b0000, 16, 1558);
        check("ref_before_access", refCasCyc, 1561);
        endCycle();

        // Abort during RCD
        @(negedge clk);
        bus.ADDR = 28'h0BE_EF00; bus.RnW = 1'b1; bus.SIZ = 2'b00; bus.nDS = 1'b0; bus.nAS = 1'b0;
        @(posedge clk);
        #2;
        bus.nAS = 1'b1; bus.nDS = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_ras_low", bus.nRAS, 0);
        @(negedge clk);
        check("abort_release", {bus.nRAS, bus.nCAS}, 5'h1F);
        repeat (10) @(negedge clk);
        check("abort_no_cas", casSeen, 4'b0000);

        // Async reset while in ACK
        access(1'b1, 2'b00, 28'h0C0_FFEC, 4'b0000, 7, 0);
        #3 rst = 1'b1;
        #1;
        check("rst_ack_strobes", {bus.nRAS, bus.nCAS, bus.nWE}, 6'h3F);
        check("rst_ack_ma", bus.MA, 0);
        check("rst_ack_dsack", bus.DSACK, 0);
        bus.nAS = 1'b1; bus.nDS = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

`ifdef DRAMCTL_BURST_EN
        begin
            exp_t e;
            logic [27:0] a;
            a = 28'h246_8AB8;
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                e.row = a[27:15]; e.col = {a[14:4], 2'(a[3:2] + b)}; e.cas = 4'b0000; e.we = 1'b1;
                e.cback = b != 3; e.t0 = cyc; e.lat = (b == 0) ? 7 : 0;
                sb.push_back(e);
            end
            bus.nCBREQ = 1'b0; bus.ADDR = a; bus.RnW = 1'b1; bus.SIZ = 2'b00; bus.nDS = 1'b0; bus.nAS = 1'b0;
            for (int b = 0; b < 4; b++) begin
                waitLeft(3 - b, 40);
                if (b < 3) begin
                    #2 bus.nDS = 1'b1;
                    repeat (3) @(posedge clk);
                    #2 bus.nDS = 1'b0;
                end
            end
            endCycle();
            bus.nCBREQ = 1'b1;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
